pe_axi_req_bridge: RTL and testbench
====================================

# pe_axi_req_bridge

Single-outstanding-transaction bridge between the PE's internal word request port (DMA/cache side) and the AXI4 master port. It converts one request into a proper single-beat AXI4 write (AW+W→B) or read (AR→R) with full valid/ready handshaking. It returns a response carrying read data, the AXI response code and local fault flags. It replaces the direct wiring of cache strobes onto AXI valids inside the PE top level.

## Interface
Parameters:
- `TIMEOUT`, 1024: response-wait limit in cycles; 0 disables the timeout.
- `ADDR_W`, 32: address width.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W, `req_wdata` in 32, `req_wstrb` in 4: request payload.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: AXI BRESP/RRESP.
- `rsp_fault` out 2: 00 none, 01 misaligned, 10 timeout.
- `busy` out 1: high in any state other than IDLE.
- AXI write: `m_awaddr` out 32, `m_awlen` out 8, `m_awsize` out 3, `m_awburst` out 2, `m_awvalid` out 1, `m_awready` in 1, `m_wdata` out 32, `m_wstrb` out 4, `m_wlast` out 1, `m_wvalid` out 1, `m_wready` in 1, `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1.
- AXI read: `m_araddr` out 32, `m_arlen` out 8, `m_arsize` out 3, `m_arburst` out 2, `m_arvalid` out 1, `m_arready` in 1, `m_rdata` in 32, `m_rresp` in 2, `m_rlast` in 1, `m_rvalid` in 1, `m_rready` out 1.

## Operation
Constant AXI fields:
- `m_awlen` = `m_arlen` = 0.
- `m_awsize` = `m_arsize` = 3'b010.
- `m_awburst` = `m_arburst` = 2'b01.
- `m_wlast` = 1.

State machine: IDLE, WADDR, WRESP, RADDR, RDATA, RSP, DRAIN.

- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, latch the request.
  - If `req_addr[1:0]` ≠ 0: go to RSP with fault 01, resp 00, rdata 0. No AXI activity.
  - Else if `req_we`: go to WADDR.
  - Else: go to RADDR.
- **WADDR:**
  - `m_awvalid` and `m_wvalid` are asserted together and drop independently on their own handshake.
  - Go to WRESP once both handshakes have completed. They may complete in the same or different cycles.
- **WRESP:**
  - `m_bready` = 1.
  - On `m_bvalid`: capture `m_bresp` and go to RSP.
- **RADDR:**
  - `m_arvalid` = 1 until `m_arready`, then go to RDATA.
- **RDATA:**
  - `m_rready` = 1.
  - On `m_rvalid`: capture `m_rdata` and `m_rresp`, then go to RSP.
  - `m_rlast` is ignored.
- **RSP:**
  - `rsp_valid` = 1, payload stable.
  - On `rsp_ready`: go to IDLE.
- **Timeout:**
  - A 32-bit wait counter clears on entry to WRESP/RDATA and increments each cycle in those states.
  - When the counter reaches `TIMEOUT`−1 with no B/R: go to DRAIN with fault 10, resp 00, rdata 0.
  - Address-phase stalls (WADDR/RADDR) never time out, because AXI forbids withdrawing valid.
- **DRAIN:**
  - `rsp_valid` = 1.
  - `m_bready` or `m_rready` is held 1 (matching the pending direction) to absorb the late response, which is discarded.
  - Exit to IDLE only when both the rsp handshake and the stale B/R have occurred, in either order or the same cycle.
- `req_ready` = 0 in every state except IDLE. There is never more than one outstanding AXI transaction.

## Timing
- **Reset values:** all valids/readies 0, `rsp_*` 0, `busy` 0, state IDLE.
- **Reset mid-transaction:** at the next edge all `m_*valid` and `m_*ready` drop and the transaction is abandoned. The AXI slave shares the same reset.
- All AXI and rsp outputs are registered. No combinational path from any input to any output, except `req_ready` (a state decode).
- **Write latency, zero wait states** (accept edge = cycle 0):
  - AW/W valid in cycle 1, handshake in cycle 1.
  - `m_bready` from cycle 2; B in cycle 2.
  - `rsp_valid` in cycle 3.
- **Read latency, zero wait states:** `m_arvalid` in cycle 1, R in cycle 2, `rsp_valid` in cycle 3.
- **Misaligned request:** `rsp_valid` in cycle 1.
- A new request can be accepted in the cycle after the `rsp_valid`&`rsp_ready` handshake.
- **Timeout, `TIMEOUT`=N:** the fault response is asserted N cycles after entering WRESP/RDATA.

## Test plan
- Write 0x1000, data 0xDEADBEEF, strb 0xF, zero-wait slave → AW/W in cycle 1 with awaddr 0x1000, wstrb 0xF; `rsp_valid` in cycle 3 with resp 00, fault 00.
- Read 0x2004, slave returns 0x12345678 RRESP 10 after 5 stall cycles on `m_arready` → `m_arvalid` held stable for 5 cycles; rsp rdata 0x12345678, resp 10.
- Write with `m_wready` delayed 3 cycles after `m_awready` → `m_awvalid` drops after its handshake, `m_wvalid` holds; exactly one B accepted; `rsp_valid` = 1.
- Read 0x3002 → no AXI valid ever asserted; `rsp_valid` next cycle with fault 01.
- `TIMEOUT`=8, read whose R arrives 20 cycles late, `rsp_ready` tied 1 → fault 10 after 8 cycles; `req_ready` stays 0 until the late R is accepted, then returns to 1.
- `rst` asserted while in WADDR with `m_awvalid`=1 → next edge `m_awvalid`=`m_wvalid`=0, `busy`=0, `req_ready`=1.

Source files
------------

// File: rtl/pe_axi_req_bridge_if.sv
// Interfaces for the PE word request port and the single-beat AXI4 master port.
// Every channel is a valid/ready pair: the source holds valid and payload stable until ready is seen at a rising edge.

interface pe_req_if #(parameter int ADDR_W = 32) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic [1:0]        rsp_resp;
   logic [1:0]        rsp_fault;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_fault, busy
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_fault, busy
   );
endinterface

interface pe_axi_if ();
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wlast;
   logic        m_wvalid;
   logic        m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid;
   logic        m_bready;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;
   logic        m_rvalid;
   logic        m_rready;

   modport master (
      output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
      output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
      output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
      input  m_awready, m_wready, m_bresp, m_bvalid,
      input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
   );
   modport slave (
      input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
      input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
      input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
      output m_awready, m_wready, m_bresp, m_bvalid,
      output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
   );
endinterface

// File: rtl/pe_axi_req_bridge.sv
// Single-outstanding bridge turning one PE word request into a single-beat AXI4 write or read.
// All AXI and response outputs are registered; only req_ready decodes the state directly.

module pe_axi_req_bridge #(
   parameter int TIMEOUT = 1024,
   parameter int ADDR_W  = 32
) (
   input  logic       clk,
   input  logic       rst,
   pe_req_if.slave    req,
   pe_axi_if.master   axi,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RSP, S_DRAIN
   } state_t;

   localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_arvalid;
   logic              r_bready;
   logic              r_rready;
   logic [31:0]       r_wait_cnt;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic [1:0]        r_rsp_resp;
   logic [1:0]        r_rsp_fault;
   logic              w_aw_done;
   logic              w_w_done;
   logic              w_timeout;
   logic              w_rsp_clear;
   logic              w_stale_clear;
   logic              w_unused_rlast;

   assign w_aw_done      = !r_awvalid || axi.m_awready;
   assign w_w_done       = !r_wvalid || axi.m_wready;
   assign w_timeout      = (TIMEOUT != 0) && (r_wait_cnt == LP_TO_LAST);
   assign w_rsp_clear    = !r_rsp_valid || req.rsp_ready;
   assign w_stale_clear  = (!r_bready || axi.m_bvalid) && (!r_rready || axi.m_rvalid);
   assign w_unused_rlast = axi.m_rlast;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req.req_valid) begin
               if (req.req_addr[1:0] != 2'b00) w_next = S_RSP;
               else if (req.req_we)            w_next = S_WADDR;
               else                            w_next = S_RADDR;
            end
         end
         S_WADDR: if (w_aw_done && w_w_done) w_next = S_WRESP;
         S_WRESP: begin
            if (axi.m_bvalid)   w_next = S_RSP;
            else if (w_timeout) w_next = S_DRAIN;
         end
         S_RADDR: if (axi.m_arready) w_next = S_RDATA;
         S_RDATA: begin
            if (axi.m_rvalid)   w_next = S_RSP;
            else if (w_timeout) w_next = S_DRAIN;
         end
         S_RSP:   if (req.rsp_ready) w_next = S_IDLE;
         // DRAIN ends only once both the fault response and the late B/R are gone.
         S_DRAIN: if (w_rsp_clear && w_stale_clear) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_bready    <= 1'b0;
         r_rready    <= 1'b0;
         r_wait_cnt  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
         r_rsp_fault <= '0;
      end else begin
         if (r_state == S_IDLE && req.req_valid) begin
            r_addr  <= req.req_addr;
            r_wdata <= req.req_wdata;
            r_wstrb <= req.req_wstrb;
         end

         // AW and W start together but retire on their own handshakes.
         if (r_state == S_IDLE && w_next == S_WADDR) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
         end else begin
            if (axi.m_awready) r_awvalid <= 1'b0;
            if (axi.m_wready)  r_wvalid  <= 1'b0;
         end

         if (r_state == S_IDLE && w_next == S_RADDR) r_arvalid <= 1'b1;
         else if (axi.m_arready)                     r_arvalid <= 1'b0;

         if (r_state != S_WRESP && w_next == S_WRESP) r_bready <= 1'b1;
         else if (axi.m_bvalid)                       r_bready <= 1'b0;

         if (r_state != S_RDATA && w_next == S_RDATA) r_rready <= 1'b1;
         else if (axi.m_rvalid)                       r_rready <= 1'b0;

         if (r_state == S_WRESP || r_state == S_RDATA) r_wait_cnt <= r_wait_cnt + 32'd1;
         else                                          r_wait_cnt <= '0;

         if (r_state == S_IDLE && w_next == S_RSP) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_fault <= 2'b01;
         end else if (r_state == S_WRESP && w_next == S_RSP) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= axi.m_bresp;
            r_rsp_fault <= 2'b00;
         end else if (r_state == S_RDATA && w_next == S_RSP) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= axi.m_rdata;
            r_rsp_resp  <= axi.m_rresp;
            r_rsp_fault <= 2'b00;
         end else if (r_state != S_DRAIN && w_next == S_DRAIN) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_fault <= 2'b10;
         end else if (r_rsp_valid && req.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign req.req_ready = (r_state == S_IDLE);
   assign req.busy      = (r_state != S_IDLE);
   assign req.rsp_valid = r_rsp_valid;
   assign req.rsp_rdata = r_rsp_rdata;
   assign req.rsp_resp  = r_rsp_resp;
   assign req.rsp_fault = r_rsp_fault;

   assign axi.m_awaddr  = 32'(r_addr);
   assign axi.m_awlen   = 8'd0;
   assign axi.m_awsize  = 3'b010;
   assign axi.m_awburst = 2'b01;
   assign axi.m_awvalid = r_awvalid;
   assign axi.m_wdata   = r_wdata;
   assign axi.m_wstrb   = r_wstrb;
   assign axi.m_wlast   = 1'b1;
   assign axi.m_wvalid  = r_wvalid;
   assign axi.m_bready  = r_bready;
   assign axi.m_araddr  = 32'(r_addr);
   assign axi.m_arlen   = 8'd0;
   assign axi.m_arsize  = 3'b010;
   assign axi.m_arburst = 2'b01;
   assign axi.m_arvalid = r_arvalid;
   assign axi.m_rready  = r_rready;

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pe_axi_req_bridge.sv
// Directed bench for pe_axi_req_bridge: stimulus pushes expected responses, a forked monitor pops them at each rsp handshake.

module tb_pe_axi_req_bridge;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   pe_req_if #(.ADDR_W(32)) req_if ();
   pe_axi_if                axi_if ();

   pe_axi_req_bridge #(.TIMEOUT(8), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req_if),
      .axi         (axi_if),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   logic [35:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response payload is packed as {rdata, resp, fault}.
   task automatic monitor();
      logic [35:0] exp;
      forever begin
         @(negedge clk);
         if (req_if.rsp_valid && req_if.rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'(req_if.rsp_valid), 64'd0);
            end else begin
               exp = exp_q.pop_front();
               chk("rsp_payload",
                   64'({req_if.rsp_rdata, req_if.rsp_resp, req_if.rsp_fault}), 64'(exp));
            end
         end
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic push, input logic [35:0] exp);
      req_if.req_valid = 1'b1;
      req_if.req_we    = we;
      req_if.req_addr  = addr;
      req_if.req_wdata = data;
      req_if.req_wstrb = strb;
      if (push) exp_q.push_back(exp);
      tick();
      req_if.req_valid = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      req_if.req_valid  = 1'b0;
      req_if.req_we     = 1'b0;
      req_if.req_addr   = '0;
      req_if.req_wdata  = '0;
      req_if.req_wstrb  = '0;
      req_if.rsp_ready  = 1'b0;
      axi_if.m_awready  = 1'b0;
      axi_if.m_wready   = 1'b0;
      axi_if.m_bresp    = 2'b00;
      axi_if.m_bvalid   = 1'b0;
      axi_if.m_arready  = 1'b0;
      axi_if.m_rdata    = '0;
      axi_if.m_rresp    = 2'b00;
      axi_if.m_rlast    = 1'b0;
      axi_if.m_rvalid   = 1'b0;
      fork monitor(); join_none

      repeat (3) tick();
      rst = 1'b0;
      chk("rst_awvalid", 64'(axi_if.m_awvalid), 64'd0);
      chk("rst_wvalid", 64'(axi_if.m_wvalid), 64'd0);
      chk("rst_arvalid", 64'(axi_if.m_arvalid), 64'd0);
      chk("rst_readies", 64'({axi_if.m_bready, axi_if.m_rready}), 64'd0);
      chk("rst_rsp", 64'({req_if.rsp_valid, req_if.rsp_rdata, req_if.rsp_resp, req_if.rsp_fault}), 64'd0);
      chk("rst_busy", 64'(req_if.busy), 64'd0);
      chk("rst_req_ready", 64'(req_if.req_ready), 64'd1);

      // Zero-wait write.
      req_if.rsp_ready = 1'b1;
      axi_if.m_awready = 1'b1;
      axi_if.m_wready  = 1'b1;
      issue(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b1, {32'h0, 2'b00, 2'b00});
      chk("w1_awvalid", 64'({axi_if.m_awvalid, axi_if.m_wvalid}), 64'b11);
      chk("w1_awaddr", 64'(axi_if.m_awaddr), 64'h1000);
      chk("w1_wdata", 64'(axi_if.m_wdata), 64'hDEADBEEF);
      chk("w1_wstrb", 64'(axi_if.m_wstrb), 64'hF);
      chk("w1_const", 64'({axi_if.m_awlen, axi_if.m_awsize, axi_if.m_awburst, axi_if.m_wlast}),
          64'({8'd0, 3'b010, 2'b01, 1'b1}));
      chk("w1_req_ready", 64'({req_if.req_ready, req_if.busy}), 64'b01);
      tick();
      chk("w1_bready_c2", 64'({axi_if.m_bready, axi_if.m_awvalid, axi_if.m_wvalid}), 64'b100);
      chk("w1_no_rsp_c2", 64'(req_if.rsp_valid), 64'd0);
      axi_if.m_bvalid = 1'b1;
      axi_if.m_bresp  = 2'b00;
      tick();
      axi_if.m_bvalid = 1'b0;
      chk("w1_rsp_valid_c3", 64'(req_if.rsp_valid), 64'd1);
      tick();
      chk("w1_idle_c4", 64'({req_if.rsp_valid, req_if.req_ready}), 64'b01);

      // Read with five cycles of AR stall.
      axi_if.m_arready = 1'b0;
      issue(1'b0, 32'h2004, 32'h0, 4'h0, 1'b1, {32'h12345678, 2'b10, 2'b00});
      for (int i = 0; i < 5; i++) begin
         chk("r2_arvalid_stall", 64'({axi_if.m_arvalid, axi_if.m_araddr}), 64'({1'b1, 32'h2004}));
         tick();
      end
      axi_if.m_arready = 1'b1;
      chk("r2_arvalid_hs", 64'(axi_if.m_arvalid), 64'd1);
      chk("r2_arconst", 64'({axi_if.m_arlen, axi_if.m_arsize, axi_if.m_arburst}), 64'({8'd0, 3'b010, 2'b01}));
      tick();
      axi_if.m_arready = 1'b0;
      chk("r2_rready", 64'({axi_if.m_arvalid, axi_if.m_rready}), 64'b01);
      axi_if.m_rvalid = 1'b1;
      axi_if.m_rdata  = 32'h12345678;
      axi_if.m_rresp  = 2'b10;
      axi_if.m_rlast  = 1'b1;
      tick();
      axi_if.m_rvalid = 1'b0;
      axi_if.m_rlast  = 1'b0;
      chk("r2_rsp_valid", 64'({req_if.rsp_valid, axi_if.m_rready}), 64'b10);
      tick();

      // Write with W accepted three cycles after AW.
      axi_if.m_awready = 1'b1;
      axi_if.m_wready  = 1'b0;
      issue(1'b1, 32'h0040, 32'hCAFEF00D, 4'h3, 1'b1, {32'h0, 2'b01, 2'b00});
      chk("w3_both_valid", 64'({axi_if.m_awvalid, axi_if.m_wvalid}), 64'b11);
      tick();
      axi_if.m_awready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) axi_if.m_wready = 1'b1;
         chk("w3_w_holds", 64'({axi_if.m_awvalid, axi_if.m_wvalid, axi_if.m_bready}), 64'b010);
         tick();
      end
      axi_if.m_wready = 1'b0;
      chk("w3_bready", 64'({axi_if.m_wvalid, axi_if.m_bready}), 64'b01);
      axi_if.m_bvalid = 1'b1;
      axi_if.m_bresp  = 2'b01;
      tick();
      axi_if.m_bvalid = 1'b0;
      chk("w3_one_b", 64'({req_if.rsp_valid, axi_if.m_bready}), 64'b10);
      tick();

      // Misaligned read never touches AXI.
      issue(1'b0, 32'h3002, 32'h0, 4'h0, 1'b1, {32'h0, 2'b00, 2'b01});
      chk("m4_rsp_c1", 64'(req_if.rsp_valid), 64'd1);
      chk("m4_no_axi", 64'({axi_if.m_awvalid, axi_if.m_wvalid, axi_if.m_arvalid}), 64'd0);
      tick();
      chk("m4_idle", 64'({req_if.req_ready, axi_if.m_arvalid}), 64'b10);

      // Read timeout: R turns up 20 cycles after RDATA entry.
      axi_if.m_arready = 1'b1;
      issue(1'b0, 32'h4000, 32'h0, 4'h0, 1'b1, {32'h0, 2'b00, 2'b10});
      chk("t5_arvalid", 64'(axi_if.m_arvalid), 64'd1);
      tick();
      axi_if.m_arready = 1'b0;
      for (int c = 2; c < 10; c++) begin
         chk("t5_waiting", 64'({req_if.rsp_valid, axi_if.m_rready}), 64'b01);
         tick();
      end
      chk("t5_fault_c10", 64'({req_if.rsp_valid, req_if.rsp_fault}), 64'({1'b1, 2'b10}));
      tick();
      for (int c = 11; c < 22; c++) begin
         chk("t5_drain", 64'({req_if.req_ready, req_if.rsp_valid, axi_if.m_rready}), 64'b001);
         tick();
      end
      axi_if.m_rvalid = 1'b1;
      axi_if.m_rdata  = 32'hAAAA5555;
      axi_if.m_rresp  = 2'b00;
      chk("t5_late_r", 64'({req_if.req_ready, axi_if.m_rready}), 64'b01);
      tick();
      axi_if.m_rvalid = 1'b0;
      chk("t5_back_idle", 64'({req_if.req_ready, req_if.busy, axi_if.m_rready}), 64'b100);

      // Write timeout: stale B absorbed before the fault response is taken.
      req_if.rsp_ready = 1'b0;
      axi_if.m_awready = 1'b1;
      axi_if.m_wready  = 1'b1;
      issue(1'b1, 32'h5000, 32'h11112222, 4'hF, 1'b1, {32'h0, 2'b00, 2'b10});
      tick();
      for (int c = 2; c < 10; c++) begin
         chk("t6_waiting", 64'({req_if.rsp_valid, axi_if.m_bready}), 64'b01);
         tick();
      end
      chk("t6_fault_c10", 64'({req_if.rsp_valid, req_if.rsp_fault, axi_if.m_bready}), 64'({1'b1, 2'b10, 1'b1}));
      axi_if.m_bvalid = 1'b1;
      axi_if.m_bresp  = 2'b11;
      tick();
      axi_if.m_bvalid = 1'b0;
      chk("t6_rsp_pending", 64'({req_if.rsp_valid, req_if.busy, axi_if.m_bready}), 64'b110);
      req_if.rsp_ready = 1'b1;
      tick();
      chk("t6_idle", 64'({req_if.busy, req_if.rsp_valid, req_if.req_ready}), 64'b001);

      // Reset while the write address phase is pending.
      axi_if.m_awready = 1'b0;
      axi_if.m_wready  = 1'b0;
      issue(1'b1, 32'h6000, 32'h0, 4'hF, 1'b0, 36'h0);
      chk("r7_awvalid", 64'({axi_if.m_awvalid, axi_if.m_wvalid}), 64'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("r7_after_rst", 64'({axi_if.m_awvalid, axi_if.m_wvalid, req_if.busy, req_if.req_ready}), 64'b0001);

      repeat (3) tick();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
